// File: rtl/hsi_pkg.sv
// ============================================================================
// hsi_pkg : shared constants, FSM state type and CRC helper for the HSI slave receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

package hsi_pkg;

    localparam logic [7:0] c_hdr_tm  = 8'hA1;
    localparam logic [7:0] c_hdr_btc = 8'hA2;
    localparam logic [7:0] c_hdr_sr  = 8'hA3;
    localparam logic [7:0] c_hdr_dpr = 8'hA4;
    localparam logic [7:0] c_hdr_ccw = 8'hA5;

    localparam logic [2:0] c_mt_none = 3'd0;
    localparam logic [2:0] c_mt_tm   = 3'd1;
    localparam logic [2:0] c_mt_btc  = 3'd2;
    localparam logic [2:0] c_mt_sr   = 3'd3;
    localparam logic [2:0] c_mt_dpr  = 3'd4;
    localparam logic [2:0] c_mt_ccw  = 3'd5;

    localparam logic [15:0] c_crc_poly = 16'h1021;
    localparam logic [15:0] c_crc_init = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    function automatic logic [2:0] hdr_to_type(input logic [7:0] hdr);
        case (hdr)
            c_hdr_tm:  return c_mt_tm;
            c_hdr_btc: return c_mt_btc;
            c_hdr_sr:  return c_mt_sr;
            c_hdr_dpr: return c_mt_dpr;
            c_hdr_ccw: return c_mt_ccw;
            default:   return c_mt_none;
        endcase
    endfunction

    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ c_crc_poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hsi_crc16_ccitt_byte.sv
// ============================================================================
// hsi_crc16_ccitt_byte : one-cycle byte-wise CRC16-CCITT update with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module hsi_crc16_ccitt_byte
    import hsi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_d,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    // A clear with a simultaneous byte restarts the CRC from that byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= c_crc_init;
        end else if (i_clr) begin
            r_crc <= i_en ? crc16_update(c_crc_init, i_d) : c_crc_init;
        end else if (i_en) begin
            r_crc <= crc16_update(r_crc, i_d);
        end
    end

    assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/hsi_slave_rx.sv
// ============================================================================
// hsi_slave_rx : HSI command-frame receiver (header, payload, CRC16 trailer)
// Define HSI_SLAVE_CRC_EN to enforce the CRC residue check.   Revision: 1.0
// ============================================================================
`default_nettype none

module hsi_slave_rx
    import hsi_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic        d_rdy,
    input  logic        dc_err,
    input  logic        msg_end,
    output logic [7:0]  q,
    output logic        q_rdy,
    output logic [2:0]  msg_type,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        crc_err,
    output logic [39:0] btc,
    output logic        btc_rdy,
    output logic        sr_req
);

    localparam int c_cnt_w = $clog2(MAX_PAYLOAD + 3);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_PAYLOAD + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_two = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_cnt_btc = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_dl0;
    logic [7:0]         r_dl1;
    logic [39:0]        r_btc_sh;

    logic [15:0] w_crc;
    logic [2:0]  w_hdr_type;
    logic        w_start;
    logic        w_take;
    logic        w_ovf;
    logic        w_len_ok;
    logic        w_crc_ok;

    assign w_hdr_type = hdr_to_type(d);
    assign w_ovf      = (r_cnt == c_cnt_max);
    assign w_start    = d_rdy && !dc_err && (r_state == ST_IDLE || r_state == ST_CHECK);
    assign w_take     = d_rdy && !dc_err && !w_ovf && (r_state == ST_RECV);

    hsi_crc16_ccitt_byte u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start),
        .i_en  (w_start | w_take),
        .i_d   (d),
        .o_crc (w_crc)
    );

`ifdef HSI_SLAVE_CRC_EN
    assign w_crc_ok = (w_crc == 16'h0000);
`else
    logic w_unused_crc;
    assign w_unused_crc = ^w_crc;
    assign w_crc_ok     = 1'b1;
`endif

    // r_cnt counts every byte after the header, so it includes the 2-byte trailer.
    always_comb begin
        w_len_ok = 1'b0;
        if (r_cnt >= c_cnt_two) begin
            case (msg_type)
                c_mt_btc: w_len_ok = (r_cnt == c_cnt_btc);
                c_mt_sr:  w_len_ok = (r_cnt == c_cnt_two);
                default:  w_len_ok = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dl0     <= '0;
            r_dl1     <= '0;
            r_btc_sh  <= '0;
            q         <= '0;
            q_rdy     <= 1'b0;
            msg_type  <= c_mt_none;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            crc_err   <= 1'b0;
            btc       <= '0;
            btc_rdy   <= 1'b0;
            sr_req    <= 1'b0;
        end else begin
            q_rdy     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            crc_err   <= 1'b0;
            btc_rdy   <= 1'b0;
            sr_req    <= 1'b0;
            case (r_state)
                ST_IDLE, ST_CHECK: begin
                    if (r_state == ST_CHECK) begin
                        if (w_crc_ok && w_len_ok) begin
                            frame_ok <= 1'b1;
                            if (msg_type == c_mt_btc) begin
                                btc     <= r_btc_sh;
                                btc_rdy <= 1'b1;
                            end
                            sr_req <= (msg_type == c_mt_sr);
                        end else begin
                            frame_err <= 1'b1;
                            crc_err   <= w_len_ok && !w_crc_ok;
                        end
                    end
                    // A byte seen here (including during CHECK) opens a new frame.
                    r_state  <= ST_IDLE;
                    msg_type <= c_mt_none;
                    if (dc_err) begin
                        r_state <= ST_DISCARD;
                    end else if (d_rdy) begin
                        r_cnt    <= '0;
                        r_btc_sh <= '0;
                        if (w_hdr_type != c_mt_none) begin
                            msg_type <= w_hdr_type;
                            r_state  <= msg_end ? ST_CHECK : ST_RECV;
                        end else if (msg_end) begin
                            frame_err <= 1'b1;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end
                end
                ST_RECV: begin
                    if (dc_err || (d_rdy && w_ovf)) begin
                        msg_type <= c_mt_none;
                        if (msg_end) begin
                            frame_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else begin
                        if (d_rdy) begin
                            r_cnt <= r_cnt + c_cnt_one;
                            r_dl0 <= d;
                            r_dl1 <= r_dl0;
                            // The oldest byte is payload only once two newer bytes exist.
                            if (r_cnt >= c_cnt_two) begin
                                q     <= r_dl1;
                                q_rdy <= 1'b1;
                                if (msg_type == c_mt_btc) begin
                                    r_btc_sh <= {r_btc_sh[31:0], r_dl1};
                                end
                            end
                        end
                        if (msg_end) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                default: begin
                    msg_type <= c_mt_none;
                    if (msg_end) begin
                        frame_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hsi_slave_rx.sv
// ============================================================================
// tb_hsi_slave_rx : directed scoreboard bench for hsi_slave_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hsi_slave_rx;

    localparam int MAXP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d;
    logic        d_rdy;
    logic        dc_err;
    logic        msg_end;
    logic [7:0]  q;
    logic        q_rdy;
    logic [2:0]  msg_type;
    logic        frame_ok;
    logic        frame_err;
    logic        crc_err;
    logic [39:0] btc;
    logic        btc_rdy;
    logic        sr_req;

    hsi_slave_rx #(.MAX_PAYLOAD(MAXP)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .d_rdy     (d_rdy),
        .dc_err    (dc_err),
        .msg_end   (msg_end),
        .q         (q),
        .q_rdy     (q_rdy),
        .msg_type  (msg_type),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .crc_err   (crc_err),
        .btc       (btc),
        .btc_rdy   (btc_rdy),
        .sr_req    (sr_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ok;
        logic        err;
        logic        cerr;
        logic        brdy;
        logic        sr;
        logic [39:0] btc;
    } ev_t;

    logic [7:0]  q_exp[$];
    ev_t         ev_exp[$];
    logic [7:0]  fr[$];
    ev_t         mon_e;
    logic [39:0] exp_btc;
    logic [15:0] sr_crc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        d = b; d_rdy = 1'b1; msg_end = e;
        tick();
        d_rdy = 1'b0; msg_end = 1'b0;
    endtask

    task automatic pulse_end();
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
    endtask

    task automatic load(input int n, input logic [63:0] v);
        fr.delete();
        for (int i = n - 1; i >= 0; i--) fr.push_back(v[i*8 +: 8]);
    endtask

    task automatic exp_q(input int n, input logic [63:0] v);
        for (int i = n - 1; i >= 0; i--) q_exp.push_back(v[i*8 +: 8]);
    endtask

    task automatic exp_ev(input logic ok, input logic err, input logic cerr,
                          input logic brdy, input logic sr, input logic [39:0] b);
        ev_t e;
        e.ok = ok; e.err = err; e.cerr = cerr; e.brdy = brdy; e.sr = sr; e.btc = b;
        ev_exp.push_back(e);
    endtask

    task automatic send_frame(input logic flip, input logic end_last);
        logic [15:0] c;
        c = crc_model(fr);
        fr.push_back(c[15:8]);
        fr.push_back(c[7:0] ^ {7'b0, flip});
        foreach (fr[i]) send(fr[i], end_last && (i == fr.size() - 1));
        if (!end_last) pulse_end();
    endtask

    always @(negedge clk) begin
        if (q_rdy) begin
            if (q_exp.size() == 0) check("q_rdy_unexpected", {63'b0, q_rdy}, 64'd0);
            else check("q_byte", {56'b0, q}, {56'b0, q_exp.pop_front()});
        end
        if (frame_ok | frame_err | crc_err | btc_rdy | sr_req) begin
            if (ev_exp.size() == 0) begin
                check("pulse_unexpected", {59'b0, frame_ok, frame_err, crc_err, btc_rdy, sr_req}, 64'd0);
            end else begin
                mon_e = ev_exp.pop_front();
                check("frame_flags", {59'b0, frame_ok, frame_err, crc_err, btc_rdy, sr_req},
                      {59'b0, mon_e.ok, mon_e.err, mon_e.cerr, mon_e.brdy, mon_e.sr});
                check("btc_value", {24'b0, btc}, {24'b0, mon_e.btc});
            end
        end
    end

    initial begin
        d = 8'h00; d_rdy = 1'b0; dc_err = 1'b0; msg_end = 1'b0; rst = 1'b1;
        exp_btc = 40'h0;
        repeat (3) tick();
        check("rst_q",         {56'b0, q},        64'd0);
        check("rst_q_rdy",     {63'b0, q_rdy},    64'd0);
        check("rst_msg_type",  {61'b0, msg_type}, 64'd0);
        check("rst_frame_ok",  {63'b0, frame_ok}, 64'd0);
        check("rst_frame_err", {63'b0, frame_err},64'd0);
        check("rst_crc_err",   {63'b0, crc_err},  64'd0);
        check("rst_btc",       {24'b0, btc},      64'd0);
        check("rst_btc_rdy",   {63'b0, btc_rdy},  64'd0);
        check("rst_sr_req",    {63'b0, sr_req},   64'd0);
        rst = 1'b0;
        tick();

        // SR frame, trailer then separate msg_end
        load(1, 64'hA3);
        sr_crc = crc_model(fr);
        exp_ev(1, 0, 0, 0, 1, exp_btc);
        send(8'hA3, 0);
        check("msg_type_sr", {61'b0, msg_type}, 64'd3);
        send(sr_crc[15:8], 0);
        send(sr_crc[7:0], 0);
        pulse_end();
        repeat (2) tick();

        // BTC frame, msg_end coincident with last trailer byte
        load(6, 64'hA2_01_02_03_04_05);
        exp_q(5, 64'h01_02_03_04_05);
        exp_btc = 40'h01_02_03_04_05;
        exp_ev(1, 0, 0, 1, 0, exp_btc);
        send_frame(0, 1);
        repeat (2) tick();

        // CCW frame with corrupted CRC LSB
        load(3, 64'hA5_11_22);
        exp_q(2, 64'h11_22);
`ifdef HSI_SLAVE_CRC_EN
        exp_ev(0, 1, 1, 0, 0, exp_btc);
`else
        exp_ev(1, 0, 0, 0, 0, exp_btc);
`endif
        send_frame(1, 0);
        repeat (2) tick();

        // unknown header
        exp_ev(0, 1, 0, 0, 0, exp_btc);
        send(8'h7E, 0);
        check("msg_type_bad_hdr", {61'b0, msg_type}, 64'd0);
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
        pulse_end();
        repeat (2) tick();

        // TM frame aborted by decoder error, then a good TM frame
        exp_q(1, 64'h31);
        exp_ev(0, 1, 0, 0, 0, exp_btc);
        send(8'hA1, 0); send(8'h31, 0); send(8'h32, 0); send(8'h33, 0);
        dc_err = 1'b1; tick(); dc_err = 1'b0;
        send(8'h34, 0); send(8'h35, 0);
        pulse_end();
        repeat (2) tick();
        load(4, 64'hA1_AA_BB_CC);
        exp_q(3, 64'hAA_BB_CC);
        exp_ev(1, 0, 0, 0, 0, exp_btc);
        send_frame(0, 0);
        repeat (2) tick();

        // too short: header plus one byte
        exp_ev(0, 1, 0, 0, 0, exp_btc);
        send(8'hA1, 0); send(8'h55, 1);
        repeat (2) tick();

        // BTC with only four payload bytes
        load(5, 64'hA2_01_02_03_04);
        exp_q(4, 64'h01_02_03_04);
        exp_ev(0, 1, 0, 0, 0, exp_btc);
        send_frame(0, 0);
        repeat (2) tick();

        // TM at the maximum payload length
        fr.delete(); fr.push_back(8'hA1);
        for (int i = 0; i < MAXP; i++) begin
            fr.push_back(8'h60 + 8'(i));
            q_exp.push_back(8'h60 + 8'(i));
        end
        exp_ev(1, 0, 0, 0, 0, exp_btc);
        send_frame(0, 0);
        repeat (2) tick();

        // TM one byte over the maximum payload length
        fr.delete(); fr.push_back(8'hA1);
        for (int i = 0; i <= MAXP; i++) fr.push_back(8'h40 + 8'(i));
        for (int i = 0; i < MAXP; i++) q_exp.push_back(8'h40 + 8'(i));
        exp_ev(0, 1, 0, 0, 0, exp_btc);
        send_frame(0, 0);
        repeat (2) tick();

        // SR ending with msg_end, next header arrives during CHECK
        exp_ev(1, 0, 0, 0, 1, exp_btc);
        send(8'hA3, 0); send(sr_crc[15:8], 0); send(sr_crc[7:0], 1);
        load(2, 64'hA1_5A);
        exp_q(1, 64'h5A);
        exp_ev(1, 0, 0, 0, 0, exp_btc);
        send_frame(0, 0);
        repeat (2) tick();

        // reset in the middle of a BTC payload, then a good SR frame
        exp_q(1, 64'h01);
        send(8'hA2, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("btc_after_rst", {24'b0, btc}, 64'd0);
        check("msg_type_after_rst", {61'b0, msg_type}, 64'd0);
        exp_btc = 40'h0;
        load(1, 64'hA3);
        exp_ev(1, 0, 0, 0, 1, exp_btc);
        send_frame(0, 0);

        repeat (5) tick();
        check("q_queue_drained",  64'(q_exp.size()),  64'd0);
        check("ev_queue_drained", 64'(ev_exp.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
